instr_buffer: RTL and testbench

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/pipe_pkg.sv | 17 +
 rtl/instr_buffer.sv | 86 ++++++++
 tb/tb_instr_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: instruction field layout, NOP/exception constants and buffer state encoding shared by fetch and decode
package pipe_pkg;
  localparam int XLEN   = 32;
  localparam int EXC_W  = 8;
  localparam int FLD_W  = 5;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 22;
  localparam int RB_MSB = 21;
  localparam int RB_LSB = 17;
  localparam int RC_MSB = 4;
  localparam int RC_LSB = 0;
  localparam logic [XLEN-1:0]  NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [EXC_W-1:0] EXC_NONE     = 8'h00;
  typedef enum logic {IB_PASS, IB_HOLD} ib_state_e;
endpackage

// File: rtl/instr_buffer.sv
// instr_buffer: decode-stage register that holds back the memory word across downstream stalls
module instr_buffer
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             stall,
  input  logic             flush,
  input  logic             bubble_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [EXC_W-1:0] exc_in,
  input  logic [XLEN-1:0]  mem_data,
  output logic             bubble_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [EXC_W-1:0] exc_out,
  output logic [XLEN-1:0]  instr_out,
  output logic [FLD_W-1:0] opcode_out,
  output logic [FLD_W-1:0] ra_out,
  output logic [FLD_W-1:0] rb_out,
  output logic [FLD_W-1:0] rc_out
);
  ib_state_e        state_q, state_d;
  logic [XLEN-1:0]  hold_word_q, hold_word_d;
  logic             bubble_q, bubble_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [EXC_W-1:0] exc_q, exc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  word;
  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    bubble_d    = bubble_q;
    pc_d        = pc_q;
    exc_d       = exc_q;
    instr_d     = instr_q;
    word        = (state_q == IB_HOLD) ? hold_word_q : mem_data;
    if (clk_en) begin
      if (flush) begin
        bubble_d    = 1'b1;
        exc_d       = EXC_NONE;
        instr_d     = NOP_WORD;
        state_d     = IB_PASS;
        hold_word_d = (state_q == IB_HOLD) ? NOP_WORD : hold_word_q;
      end else if (stall) begin
        // the memory word only arrives once, so grab it on the first stalled cycle
        hold_word_d = (state_q == IB_PASS) ? mem_data : hold_word_q;
        state_d     = IB_HOLD;
      end else begin
        bubble_d = bubble_in;
        pc_d     = pc_in;
        exc_d    = exc_in;
        instr_d  = (!bubble_in && exc_in == EXC_NONE) ? word : NOP_WORD;
        state_d  = IB_PASS;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IB_PASS;
      hold_word_q <= NOP_WORD;
      bubble_q    <= 1'b1;
      pc_q        <= RESET_PC;
      exc_q       <= EXC_NONE;
      instr_q     <= NOP_WORD;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      bubble_q    <= bubble_d;
      pc_q        <= pc_d;
      exc_q       <= exc_d;
      instr_q     <= instr_d;
    end
  end
  assign bubble_out = bubble_q;
  assign pc_out     = pc_q;
  assign exc_out    = exc_q;
  assign instr_out  = instr_q;
  assign opcode_out = instr_q[OP_MSB:OP_LSB];
  assign ra_out     = instr_q[RA_MSB:RA_LSB];
  assign rb_out     = instr_q[RB_MSB:RB_LSB];
  assign rc_out     = instr_q[RC_MSB:RC_LSB];
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: directed and random checks of instr_buffer against a transaction-level model
module tb_instr_buffer;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0400;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, stall, flush, bubble_in;
  logic [31:0] pc_in, mem_data;
  logic [7:0]  exc_in;
  logic        bubble_out;
  logic [31:0] pc_out, instr_out;
  logic [7:0]  exc_out;
  logic [4:0]  opcode_out, ra_out, rb_out, rc_out;
  int checks = 0;
  int errors = 0;
  logic        m_bubble;
  logic [31:0] m_pc, m_instr;
  logic [7:0]  m_exc;
  logic [31:0] pend_q[$];
  bit          m_pend;
  logic [92:0] got;
  logic [31:0] snap;
  instr_buffer #(.NOP_WORD(NOP), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .stall(stall), .flush(flush),
    .bubble_in(bubble_in), .pc_in(pc_in), .exc_in(exc_in), .mem_data(mem_data),
    .bubble_out(bubble_out), .pc_out(pc_out), .exc_out(exc_out), .instr_out(instr_out),
    .opcode_out(opcode_out), .ra_out(ra_out), .rb_out(rb_out), .rc_out(rc_out)
  );
  always #5 clk = ~clk;
  assign got = {bubble_out, pc_out, exc_out, instr_out, opcode_out, ra_out, rb_out, rc_out};
  function automatic logic [92:0] mexp();
    return {m_bubble, m_pc, m_exc, m_instr, m_instr[31:27], m_instr[26:22], m_instr[21:17], m_instr[4:0]};
  endfunction
  function automatic void mdl_reset();
    m_bubble = 1'b1;
    m_pc     = RPC;
    m_exc    = 8'h00;
    m_instr  = NOP;
    pend_q.delete();
    m_pend   = 1'b0;
  endfunction
  // a stalled fetch keeps its memory word in a pending slot until the stage can accept it
  function automatic void mdl_step();
    logic [31:0] w;
    if (!rst_n || !clk_en) return;
    if (flush) begin
      m_bubble = 1'b1;
      m_exc    = 8'h00;
      m_instr  = NOP;
      pend_q.delete();
    end else if (stall) begin
      if (pend_q.size() == 0) pend_q.push_back(mem_data);
    end else begin
      w        = (pend_q.size() != 0) ? pend_q.pop_front() : mem_data;
      m_bubble = bubble_in;
      m_pc     = pc_in;
      m_exc    = exc_in;
      m_instr  = (!bubble_in && exc_in == 8'h00) ? w : NOP;
    end
    m_pend = pend_q.size() != 0;
  endfunction
  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
  endtask
  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] pc,
                       input logic [7:0] e, input logic [31:0] md);
    stall = s; flush = f; bubble_in = b; pc_in = pc; exc_in = e; mem_data = md;
  endtask
  a_latency: assert property (@(posedge clk) disable iff (!rst_n)
    (clk_en && !flush && !stall && !m_pend && !bubble_in && exc_in == 8'h00) |=> instr_out == $past(mem_data))
    else begin errors++; $display("FAIL latency: instr_out %h req %h", instr_out, $past(mem_data)); end
  a_reset: assert property (@(posedge clk) !rst_n |->
    (bubble_out && pc_out == RPC && exc_out == 8'h00 && instr_out == NOP))
    else begin errors++; $display("FAIL reset_vals: b=%b pc=%h exc=%h instr=%h", bubble_out, pc_out, exc_out, instr_out); end
  task automatic test_reset();
    repeat (2) tick();
    checks++;
    assert (bubble_out === 1'b1 && pc_out === RPC && exc_out === 8'h00 && instr_out === NOP)
      else begin errors++; $display("FAIL reset: got %h req %h", got, mexp()); end
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    drive(0, 0, 0, 32'h400, 8'h00, 32'h1234_5678);
    tick();
    checks++;
    if (got !== mexp()) begin errors++; $display("FAIL basic_model: got %h req %h", got, mexp()); end
    checks++;
    if ({bubble_out, pc_out, instr_out, opcode_out} !== {1'b0, 32'h400, 32'h1234_5678, 5'h02}) begin
      errors++; $display("FAIL basic: b=%b pc=%h instr=%h op=%h req 0 400 12345678 02", bubble_out, pc_out, instr_out, opcode_out);
    end
  endtask
  task automatic test_stall();
    drive(1, 0, 0, 32'h404, 8'h00, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_out !== 32'h1234_5678 || pc_out !== 32'h400 || got !== mexp()) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h req %h", i, got, mexp());
      end
      mem_data = 32'hDEAD_BEEF;
    end
    stall = 1'b0;
    tick();
    checks++;
    if (instr_out !== 32'hAAAA_0001 || pc_out !== 32'h404 || got !== mexp()) begin
      errors++; $display("FAIL stall_release: instr %h req aaaa0001 (full %h vs %h)", instr_out, got, mexp());
    end
  endtask
  task automatic test_flush_hold();
    drive(1, 0, 0, 32'h408, 8'h00, 32'h7000_0007);
    tick();
    drive(1, 1, 0, 32'h408, 8'h00, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (bubble_out !== 1'b1 || instr_out !== NOP || exc_out !== 8'h00 || got !== mexp()) begin
      errors++; $display("FAIL flush_hold: got %h req %h", got, mexp());
    end
    drive(0, 0, 0, 32'h40C, 8'h00, 32'h0BAD_F00D);
    tick();
    checks++;
    if (instr_out !== 32'h0BAD_F00D || pc_out !== 32'h40C || bubble_out !== 1'b0) begin
      errors++; $display("FAIL flush_after: instr %h pc %h req 0badf00d 40c", instr_out, pc_out);
    end
  endtask
  task automatic test_exc();
    drive(0, 0, 0, 32'h402, 8'h84, 32'h5555_5555);
    tick();
    checks++;
    if ({exc_out, pc_out, instr_out, bubble_out} !== {8'h84, 32'h402, NOP, 1'b0}) begin
      errors++; $display("FAIL exc: exc %h pc %h instr %h b %b req 84 402 %h 0", exc_out, pc_out, instr_out, bubble_out, NOP);
    end
  endtask
  task automatic test_clk_en();
    snap = instr_out;
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i[0], !i[0], 0, $urandom, 8'h00, $urandom);
      tick();
      checks++;
      if (got !== mexp() || instr_out !== snap) begin
        errors++; $display("FAIL clk_en_freeze[%0d]: got %h req %h", i, got, mexp());
      end
    end
    clk_en = 1'b1;
    drive(0, 0, 0, 32'h500, 8'h00, 32'h1111_2222);
    tick();
    drive(1, 0, 0, 32'h504, 8'h00, 32'h7777_7777);
    tick();
    #2 rst_n = 1'b0;
    mdl_reset();
    #1;
    checks++;
    if (pc_out !== 32'h400 || bubble_out !== 1'b1 || instr_out !== NOP || exc_out !== 8'h00) begin
      errors++; $display("FAIL async_reset: pc %h b %b instr %h exc %h", pc_out, bubble_out, instr_out, exc_out);
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 32'h600, 8'h00, 32'h55AA_55AA);
    tick();
    checks++;
    if (instr_out !== 32'h55AA_55AA || got !== mexp()) begin
      errors++; $display("FAIL post_reset_pass: got %h req %h", got, mexp());
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clk_en    = $urandom_range(99) < 85;
      drive($urandom_range(99) < 30, $urandom_range(99) < 10, $urandom_range(99) < 20,
            $urandom, ($urandom_range(99) < 15) ? 8'($urandom_range(255, 1)) : 8'h00, $urandom);
      tick();
      checks++;
      if (got !== mexp()) begin errors++; $display("FAIL random[%0d]: got %h req %h", i, got, mexp()); end
    end
    clk_en = 1'b1;
  endtask
  initial begin
    rst_n = 1'b1;
    clk_en = 1'b1;
    drive(0, 0, 1, 32'h0, 8'h00, 32'h0);
    mdl_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_flush_hold();
    test_exc();
    test_clk_en();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
